// File: rtl/led_matrix_capture_if.sv
// Frame delivery bus of the LED matrix capture block: two 8x8 bitmaps
// plus a valid/ready handshake. The capture block is the master.

interface led_matrix_capture_if;
    logic [7:0][7:0] red_frame;
    logic [7:0][7:0] green_frame;
    logic            frame_valid;
    logic            frame_ready;

    modport master (
        output red_frame,
        output green_frame,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  red_frame,
        input  green_frame,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/led_matrix_capture.sv
// Rebuilds 8x8 red/green frames from the row/column drive of an LED matrix.
// Define LED_CAPTURE_SYNC_EN to put a 2-flop synchroniser on all 24 inputs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset or timeout, waiting for the inputs to move
// SETTLE  | inputs changed, counting identical samples before accepting
// LATCHED | current row evaluated, holding until the inputs change again

module led_matrix_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 4096
) (
    input  logic                 clock,
    input  logic                 rst_b,
    input  logic [7:0]           row_sel,
    input  logic [7:0]           red_n,
    input  logic [7:0]           green_n,
    input  logic                 clear_err,
    led_matrix_capture_if.master frame_bus,
    output logic [15:0]          frame_count,
    output logic                 overflow,
    output logic                 err_multi,
    output logic                 no_signal
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LATCHED
    } state_t;

    state_t           state_q, state_d;
    logic [23:0]      samp, prev_q;
    logic [7:0]       row_s, red_s, green_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q;
    logic [7:0]       mask_q, mask_or;
    logic [7:0][7:0]  work_red_q, work_green_q;
    logic [7:0][7:0]  red_q, green_q;
    logic             valid_q, done_q;
    logic             row_onehot, row_multi;
    logic             accept, row_write, multi_hit, timeout_hit, complete;
    logic             load, drop;

`ifdef LED_CAPTURE_SYNC_EN
    logic [23:0] sync1_q, sync2_q;

    always_ff @(posedge clock) begin
        if (!rst_b) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {row_sel, red_n, green_n};
            sync2_q <= sync1_q;
        end
    end

    assign samp = sync2_q;
`else
    assign samp = {row_sel, red_n, green_n};
`endif

    assign row_s      = samp[23:16];
    assign red_s      = samp[15:8];
    assign green_s    = samp[7:0];
    assign row_onehot = $onehot(row_s);
    assign row_multi  = !row_onehot && (row_s != 8'h00);

    always_ff @(posedge clock) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        row_write   = 1'b0;
        multi_hit   = 1'b0;
        timeout_hit = 1'b0;
        complete    = 1'b0;
        mask_or     = mask_q | row_s;

        if (samp != prev_q) begin
            cnt_d   = '0;
            state_d = SETTLE;
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            // Accept on the sample that brings the run of identical samples to STABLE_CYCLES.
            if (state_q == SETTLE && cnt_d == CNT_MAX) begin
                accept  = 1'b1;
                state_d = LATCHED;
            end
        end

        row_write   = accept && row_onehot;
        multi_hit   = accept && row_multi;
        complete    = row_write && (mask_or == 8'hFF);
        timeout_hit = !row_write && (tmr_q == TMR_LAST);
        if (timeout_hit) state_d = IDLE;
    end

    assign load = done_q && (!valid_q || frame_bus.frame_ready);
    assign drop = done_q && valid_q && !frame_bus.frame_ready;

    always_ff @(posedge clock) begin
        if (!rst_b) begin
            prev_q       <= '0;
            cnt_q        <= '0;
            tmr_q        <= '0;
            mask_q       <= '0;
            work_red_q   <= '0;
            work_green_q <= '0;
            red_q        <= '0;
            green_q      <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            frame_count  <= '0;
            overflow     <= 1'b0;
            err_multi    <= 1'b0;
            no_signal    <= 1'b1;
        end else begin
            prev_q <= samp;
            cnt_q  <= cnt_d;

            if (row_write) begin
                for (int r = 0; r < 8; r++) begin
                    if (row_s[r]) begin
                        work_red_q[r]   <= ~red_s;
                        work_green_q[r] <= ~green_s;
                    end
                end
                tmr_q     <= '0;
                no_signal <= 1'b0;
            end else if (tmr_q != TMR_MAX) begin
                tmr_q <= tmr_q + TMR_W'(1);
            end

            if (timeout_hit) begin
                mask_q    <= '0;
                no_signal <= 1'b1;
            end else if (complete) begin
                mask_q <= '0;
            end else if (row_write) begin
                mask_q <= mask_or;
            end

            // Work registers are stable for the cycle after completion, so load one cycle late.
            done_q <= complete;

            if (load) begin
                red_q       <= work_red_q;
                green_q     <= work_green_q;
                valid_q     <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end else if (valid_q && frame_bus.frame_ready) begin
                valid_q <= 1'b0;
            end

            overflow  <= (overflow && !clear_err) || drop;
            err_multi <= (err_multi && !clear_err) || multi_hit;
        end
    end

    assign frame_bus.red_frame   = red_q;
    assign frame_bus.green_frame = green_q;
    assign frame_bus.frame_valid = valid_q;

endmodule
